// File: rtl/decode_pipe.sv
// Registered decode stage for the 16-bit-instruction core: valid/ready input,
// internal register file, ID/EX output register, load-use interlock and sticky halt.
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_pc,
    input  logic [15:0]       in_pc_plus1,
    input  logic [15:0]       in_inst,
    input  logic              wb_en,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_pc,
    output logic [15:0]       out_inst,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic [2:0]        out_wreg,
    output logic              out_wen,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic              out_rq_imm,
    output logic              out_rs_imm,
    output logic [3:0]        out_alu_ctrl,
    output logic              out_halt,
    output logic              o_dbg_state
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [DATA_W-1:0] r_rf [8];
    logic [0:0]        r_state;
    logic              r_shadow_valid;
    logic [2:0]        r_shadow_reg;

    logic              r_out_valid;
    logic [15:0]       r_out_pc;
    logic [15:0]       r_out_inst;
    logic [DATA_W-1:0] r_out_reg1;
    logic [DATA_W-1:0] r_out_reg2;
    logic [2:0]        r_out_wreg;
    logic              r_out_wen;
    logic              r_out_branch;
    logic              r_out_jump;
    logic              r_out_mem_write;
    logic              r_out_mem_read;
    logic              r_out_rq_imm;
    logic              r_out_rs_imm;
    logic [3:0]        r_out_alu_ctrl;
    logic              r_out_halt;

    logic [3:0]        w_op;
    logic [2:0]        w_rdrq_idx;
    logic [2:0]        w_rs_idx;
    logic              w_is_halt;
    logic [3:0]        w_alu_ctrl;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_wb_ok;
    logic              w_hazard;
    logic              w_ready;
    logic              w_accept;
    logic              w_load_xfer;

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; flush overrides any transfer into the output register.
    assign w_op       = in_inst[15:12];
    assign w_rdrq_idx = in_inst[14] ? in_inst[11:9] : in_inst[5:3];
    assign w_rs_idx   = in_inst[8:6];
    assign w_is_halt  = (w_op == 4'b0000);
    assign w_wb_ok    = wb_en && (32'(wb_reg) < NREG);

    always_comb begin
        w_alu_ctrl = 4'b1111;
        case (w_op)
            4'b1100: w_alu_ctrl = 4'b0000;
            4'b1101: w_alu_ctrl = 4'b0001;
            4'b1110: w_alu_ctrl = 4'b0010;
            4'b1111: w_alu_ctrl = 4'b0011;
            4'b1011: w_alu_ctrl = (in_inst[2:0] != 3'b000) ? {1'b0, in_inst[2:0]} : 4'b1000;
            4'b1010: w_alu_ctrl = {1'b1, in_inst[2:0]};
            default: w_alu_ctrl = 4'b1111;
        endcase
    end

    // Unimplemented indices read as zero; bypass forwards a same-cycle writeback.
    always_comb begin
        w_rd1 = '0;
        if (32'(w_rdrq_idx) < NREG) begin
            if (BYPASS && w_wb_ok && (wb_reg == w_rdrq_idx)) w_rd1 = wb_data;
            else                                            w_rd1 = r_rf[w_rdrq_idx];
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (32'(w_rs_idx) < NREG) begin
            if (BYPASS && w_wb_ok && (wb_reg == w_rs_idx)) w_rd2 = wb_data;
            else                                          w_rd2 = r_rf[w_rs_idx];
        end
    end

    assign w_hazard    = r_shadow_valid && in_valid &&
                         ((r_shadow_reg == w_rdrq_idx) || (r_shadow_reg == w_rs_idx));
    assign w_ready     = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept    = in_valid && w_ready && !flush;
    assign w_load_xfer = r_out_valid && out_ready && r_out_mem_read;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else if (w_wb_ok) begin
            r_rf[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_shadow_valid <= 1'b0;
            r_shadow_reg   <= 3'b000;
        end else begin
            if (flush)                      r_state <= ST_RUN;
            else if (w_accept && w_is_halt) r_state <= ST_HALTED;
            r_shadow_valid <= !flush && w_load_xfer;
            r_shadow_reg   <= r_out_wreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= '0;
            r_out_inst      <= '0;
            r_out_reg1      <= '0;
            r_out_reg2      <= '0;
            r_out_wreg      <= '0;
            r_out_wen       <= 1'b0;
            r_out_branch    <= 1'b0;
            r_out_jump      <= 1'b0;
            r_out_mem_write <= 1'b0;
            r_out_mem_read  <= 1'b0;
            r_out_rq_imm    <= 1'b0;
            r_out_rs_imm    <= 1'b0;
            r_out_alu_ctrl  <= '0;
            r_out_halt      <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_pc        <= w_is_halt ? in_pc : in_pc_plus1;
            r_out_inst      <= in_inst;
            r_out_reg1      <= w_rd1;
            r_out_reg2      <= w_rd2;
            r_out_wreg      <= in_inst[11:9];
            r_out_wen       <= in_inst[15];
            r_out_branch    <= (w_op == 4'b0010);
            r_out_jump      <= (w_op == 4'b0100);
            r_out_mem_write <= (w_op == 4'b0111);
            r_out_mem_read  <= (w_op == 4'b1000);
            r_out_rq_imm    <= (w_op == 4'b1000) || (w_op == 4'b0111);
            r_out_rs_imm    <= !in_inst[13] && !w_is_halt;
            r_out_alu_ctrl  <= w_alu_ctrl;
            r_out_halt      <= w_is_halt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready      = w_ready;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_inst      = r_out_inst;
    assign out_reg1      = r_out_reg1;
    assign out_reg2      = r_out_reg2;
    assign out_wreg      = r_out_wreg;
    assign out_wen       = r_out_wen;
    assign out_branch    = r_out_branch;
    assign out_jump      = r_out_jump;
    assign out_mem_write = r_out_mem_write;
    assign out_mem_read  = r_out_mem_read;
    assign out_rq_imm    = r_out_rq_imm;
    assign out_rs_imm    = r_out_rs_imm;
    assign out_alu_ctrl  = r_out_alu_ctrl;
    assign out_halt      = r_out_halt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: decode table, directed corner sequences and random
// traffic against a cycle-level reference model (two instances: bypass/8 regs, no bypass/4 regs).
module tb_decode_pipe;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready, wb_en;
    logic [15:0]   in_pc, in_pc_plus1, in_inst;
    logic [2:0]    wb_reg;
    logic [DW-1:0] wb_data;

    logic          in_ready, out_valid, out_wen, out_branch, out_jump, out_mem_write;
    logic          out_mem_read, out_rq_imm, out_rs_imm, out_halt, dbg_state;
    logic [15:0]   out_pc, out_inst;
    logic [DW-1:0] out_reg1, out_reg2;
    logic [2:0]    out_wreg;
    logic [3:0]    out_alu_ctrl;

    logic          in_ready_b, out_valid_b, out_wen_b, out_branch_b, out_jump_b, out_mem_write_b;
    logic          out_mem_read_b, out_rq_imm_b, out_rs_imm_b, out_halt_b, dbg_state_b;
    logic [15:0]   out_pc_b, out_inst_b;
    logic [DW-1:0] out_reg1_b, out_reg2_b;
    logic [2:0]    out_wreg_b;
    logic [3:0]    out_alu_ctrl_b;

    decode_pipe #(.DATA_W(DW), .NREG(8), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_plus1(in_pc_plus1), .in_inst(in_inst),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wreg(out_wreg), .out_wen(out_wen),
        .out_branch(out_branch), .out_jump(out_jump), .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .out_rq_imm(out_rq_imm), .out_rs_imm(out_rs_imm),
        .out_alu_ctrl(out_alu_ctrl), .out_halt(out_halt), .o_dbg_state(dbg_state)
    );

    decode_pipe #(.DATA_W(DW), .NREG(4), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_pc_plus1(in_pc_plus1), .in_inst(in_inst),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_inst(out_inst_b),
        .out_reg1(out_reg1_b), .out_reg2(out_reg2_b), .out_wreg(out_wreg_b), .out_wen(out_wen_b),
        .out_branch(out_branch_b), .out_jump(out_jump_b), .out_mem_write(out_mem_write_b),
        .out_mem_read(out_mem_read_b), .out_rq_imm(out_rq_imm_b), .out_rs_imm(out_rs_imm_b),
        .out_alu_ctrl(out_alu_ctrl_b), .out_halt(out_halt_b), .o_dbg_state(dbg_state_b)
    );

    typedef struct packed {
        logic [15:0]   pc;
        logic [15:0]   inst;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [2:0]    wreg;
        logic          wen, br, jmp, mw, mr, rqi, rsi;
        logic [3:0]    alu;
        logic          halt;
    } dec_t;

    typedef struct {
        logic [15:0] inst;
        logic [3:0]  alu;
        logic [6:0]  flags;   // {branch, jump, mem_write, mem_read, rq_imm, rs_imm, halt}
    } vec_t;

    dec_t d_a, d_b;
    assign d_a = {out_pc, out_inst, out_reg1, out_reg2, out_wreg, out_wen, out_branch, out_jump,
                  out_mem_write, out_mem_read, out_rq_imm, out_rs_imm, out_alu_ctrl, out_halt};
    assign d_b = {out_pc_b, out_inst_b, out_reg1_b, out_reg2_b, out_wreg_b, out_wen_b, out_branch_b,
                  out_jump_b, out_mem_write_b, out_mem_read_b, out_rq_imm_b, out_rs_imm_b,
                  out_alu_ctrl_b, out_halt_b};

    // Reference model state
    logic [DW-1:0] m_rf [8];
    logic          m_valid, m_shadow_v, m_halted;
    logic [2:0]    m_shadow_reg;
    dec_t          m_out, m_out_b;

    int total = 0;
    int bad   = 0;
    vec_t tbl [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] rdrq_of(input logic [15:0] i);
        return i[14] ? i[11:9] : i[5:3];
    endfunction

    function automatic logic [DW-1:0] rd(input logic [2:0] idx, input bit byp, input int nreg);
        if (int'(idx) >= nreg) return '0;
        if (byp && wb_en && (wb_reg == idx)) return wb_data;
        return m_rf[idx];
    endfunction

    function automatic dec_t model_dec(input logic [15:0] i, input logic [15:0] pc,
                                       input logic [15:0] pc1, input bit byp, input int nreg);
        dec_t d;
        int   op;
        op     = int'(i[15:12]);
        d.pc   = (op == 0) ? pc : pc1;
        d.inst = i;
        d.r1   = rd(rdrq_of(i), byp, nreg);
        d.r2   = rd(i[8:6], byp, nreg);
        d.wreg = i[11:9];
        d.wen  = i[15];
        d.br   = (op == 2);
        d.jmp  = (op == 4);
        d.mw   = (op == 7);
        d.mr   = (op == 8);
        d.rqi  = (op == 7) || (op == 8);
        d.rsi  = !i[13] && (op != 0);
        if (op >= 12)      d.alu = 4'(op - 12);
        else if (op == 11) d.alu = (i[2:0] == 3'd0) ? 4'd8 : 4'(i[2:0]);
        else if (op == 10) d.alu = 4'(8 + int'(i[2:0]));
        else               d.alu = 4'd15;
        d.halt = (op == 0);
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_valid = 1'b0; m_shadow_v = 1'b0; m_shadow_reg = 3'd0; m_halted = 1'b0;
        m_out = '0; m_out_b = '0;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        logic haz, rdy, acc, xfer;
        dec_t na, nb;
        #1;
        haz = m_shadow_v && in_valid &&
              ((m_shadow_reg == rdrq_of(in_inst)) || (m_shadow_reg == in_inst[8:6]));
        rdy = !m_halted && (!m_valid || out_ready) && !haz;
        check("in_ready", in_ready, rdy);
        check("in_ready_b", in_ready_b, rdy);
        acc  = in_valid && rdy && !flush;
        na   = model_dec(in_inst, in_pc, in_pc_plus1, 1'b1, 8);
        nb   = model_dec(in_inst, in_pc, in_pc_plus1, 1'b0, 4);
        xfer = m_valid && out_ready && m_out.mr;
        @(posedge clk);
        m_shadow_reg = m_out.wreg;
        m_shadow_v   = !flush && xfer;
        if (flush) m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m_out = na; m_out_b = nb; end
        else if (out_ready) m_valid = 1'b0;
        if (flush) m_halted = 1'b0;
        else if (acc && (in_inst[15:12] == 4'd0)) m_halted = 1'b1;
        if (wb_en) m_rf[wb_reg] = wb_data;
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_valid_b", out_valid_b, m_valid);
        check("halted_state", dbg_state, m_halted);
        check("halted_state_b", dbg_state_b, m_halted);
        if (m_valid) begin
            check("out_fields", d_a, m_out);
            check("out_fields_b", d_b, m_out_b);
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{16'hC250, 4'h0, 7'b0000010};
        tbl[1]  = '{16'hD000, 4'h1, 7'b0000010};
        tbl[2]  = '{16'hE000, 4'h2, 7'b0000000};
        tbl[3]  = '{16'hF000, 4'h3, 7'b0000000};
        tbl[4]  = '{16'hB005, 4'h5, 7'b0000000};
        tbl[5]  = '{16'hB000, 4'h8, 7'b0000000};
        tbl[6]  = '{16'hA003, 4'hB, 7'b0000000};
        tbl[7]  = '{16'h2000, 4'hF, 7'b1000000};
        tbl[8]  = '{16'h4000, 4'hF, 7'b0100010};
        tbl[9]  = '{16'h7000, 4'hF, 7'b0010100};
        tbl[10] = '{16'h8240, 4'hF, 7'b0001110};
        tbl[11] = '{16'h3000, 4'hF, 7'b0000000};

        rst = 1'b0; idle(); in_inst = '0; in_pc = '0; in_pc_plus1 = '0; wb_reg = '0; wb_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_fields", d_a, 0);
        check("reset_ready", in_ready, 0 == 1 ? 0 : in_valid ? 1 : 1);
        rst = 1'b1;
        step();

        // ALU add after writing r1=5, r2=7
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 32'd5; step();
        wb_reg = 3'd2; wb_data = 32'd7; step();
        wb_en = 1'b0;
        in_valid = 1'b1; in_inst = 16'hC250; in_pc = 16'h0100; in_pc_plus1 = 16'h0101; step();
        check("add_valid", out_valid, 1);
        check("add_alu", out_alu_ctrl, 4'b0000);
        check("add_reg2", out_reg2, 32'd5);
        check("add_wen", out_wen, 1);
        check("add_pc", out_pc, 16'h0101);
        idle(); step();

        // Same-cycle writeback to the source register
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 32'hA5; in_valid = 1'b1; in_inst = 16'hC250; step();
        check("bypass_on_reg2", out_reg2, 32'hA5);
        check("bypass_off_reg2", out_reg2_b, 32'd5);
        idle(); step();

        // Register index beyond NREG on the 4-entry instance
        wb_en = 1'b1; wb_reg = 3'd5; wb_data = 32'h55; step();
        wb_en = 1'b0; in_valid = 1'b1; in_inst = 16'hC140; step();
        check("r5_nreg8", out_reg2, 32'h55);
        check("r5_nreg4", out_reg2_b, 32'd0);
        idle(); step();

        // Load-use: dependent follower gets exactly one bubble
        in_valid = 1'b1; in_inst = 16'h8240; step();
        in_inst = 16'hC000; step();
        in_inst = 16'hC040; #1 check("lu_stall_ready", in_ready, 0);
        step();
        check("lu_bubble", out_valid, 0);
        step();
        check("lu_dep_valid", out_valid, 1);
        check("lu_dep_inst", out_inst, 16'hC040);
        idle(); step();

        // Load followed by non-dependent instructions: no bubble
        in_valid = 1'b1; in_inst = 16'h8240; step();
        in_inst = 16'hC000; step();
        in_inst = 16'hC080; step();
        check("nodep_valid", out_valid, 1);
        check("nodep_inst", out_inst, 16'hC080);
        idle(); step();

        // Halt is sticky until flush
        in_valid = 1'b1; in_inst = 16'h0000; in_pc = 16'h0010; in_pc_plus1 = 16'h0011; step();
        check("halt_flag", out_halt, 1);
        check("halt_pc", out_pc, 16'h0010);
        for (int i = 0; i < 10; i++) begin
            in_inst = 16'(16'hC000 | 16'($urandom_range(0, 4095)));
            #1 check("halted_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0; #1 check("post_flush_ready", in_ready, 1);
        step();

        // Backpressure: hold for 3 cycles, then release
        in_valid = 1'b1; in_inst = 16'hD048; step();
        out_ready = 1'b0; in_inst = 16'hE0C8;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", in_ready, 0);
            step();
            check("bp_hold_inst", out_inst, 16'hD048);
        end
        out_ready = 1'b1; step();
        check("bp_next_inst", out_inst, 16'hE0C8);
        idle(); step();
        check("bp_no_dup", out_valid, 0);

        // Reset asserted while the output is stalled
        in_valid = 1'b1; in_inst = 16'hC250; step();
        in_valid = 1'b0; out_ready = 1'b0; step();
        rst = 1'b0;
        #1 check("rst_mid_valid", out_valid, 0);
        check("rst_mid_fields", d_a, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1; idle(); step();
        in_valid = 1'b1; in_inst = 16'hC250; step();
        check("rst_rf_reg1", out_reg1, 0);
        check("rst_rf_reg2", out_reg2, 0);
        idle(); step();

        // Decode table
        foreach (tbl[k]) begin
            idle(); in_valid = 1'b1; in_inst = tbl[k].inst; step();
            check("tbl_alu", out_alu_ctrl, tbl[k].alu);
            check("tbl_flags", {out_branch, out_jump, out_mem_write, out_mem_read,
                                out_rq_imm, out_rs_imm, out_halt}, tbl[k].flags);
            in_valid = 1'b0; step();
        end

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_inst     = 16'($urandom);
            in_pc       = 16'($urandom);
            in_pc_plus1 = in_pc + 16'd1;
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_en       = ($urandom_range(0, 1) == 1);
            wb_reg      = 3'($urandom_range(0, 7));
            wb_data     = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, registered decode stage for the 16-bit-instruction core.
- Takes one fetched instruction per valid/ready handshake and decodes the control signals.
- Reads operands from an internal NREG x DATA_W register file with optional write-through bypass.
- Presents the result through an ID/EX output register. Adds what the combinational decoder lacks: backpressure, flush, load-use interlock, and a sticky halted state.

Parameters:
- DATA_W, 32, register/operand data width.
- NREG, 8, implemented registers (2..8). Indices >= NREG read 0; writes to them are dropped.
- BYPASS, 1, 1 = a same-cycle writeback to a read register forwards wb_data; 0 = the old value is read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  squash the output register and the instruction being accepted; clear HALTED.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  16  PC of the instruction.
- in_pc_plus1  in  16  PC+1.
- in_inst  in  16  instruction word.
- wb_en  in  1  register-file write enable.
- wb_reg  in  3  write index.
- wb_data  in  DATA_W  write data.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  execute consumes.
- out_pc  out  16  next PC: in_pc if halt, else in_pc_plus1.
- out_inst  out  16  instruction passthrough.
- out_reg1  out  DATA_W  operand from the RdRq index.
- out_reg2  out  DATA_W  operand from the Rs index.
- out_wreg  out  3  inst[11:9].
- out_wen  out  1  inst[15].
- out_branch  out  1  opcode 0010.
- out_jump  out  1  opcode 0100.
- out_mem_write  out  1  opcode 0111.
- out_mem_read  out  1  opcode 1000.
- out_rq_imm  out  1  opcode 1000 or 0111.
- out_rs_imm  out  1  ~inst[13] & ~halt.
- out_alu_ctrl  out  4  ALU operation.
- out_halt  out  1  opcode 0000.

Behaviour:
- Decode fields:
  - opcode = inst[15:12].
  - RdRq index = inst[14] ? inst[11:9] : inst[5:3].
  - Rs index = inst[8:6].
- ALU control mapping:
  - 1100->0000, 1101->0001, 1110->0010, 1111->0011.
  - 1011-> {0,inst[2:0]} if inst[2:0]!=0, else 1000.
  - 1010-> {1,inst[2:0]}.
  - All other opcodes -> 1111.
- Register file:
  - Synchronous write on clk when wb_en and wb_reg<NREG.
  - Combinational read, with bypass per BYPASS.
  - Reset clears all entries to 0.
- Output register:
  - Loads all out_* fields on accept (in_valid & in_ready & ~flush). Latency is one cycle from accept to out_valid.
  - Holds its contents while out_valid & ~out_ready.
  - in_ready = state==RUN & (~out_valid | out_ready) & ~hazard.
  - out_valid clears when it is consumed with no new accept, or on flush.
- States: RUN, HALTED.
  - RUN->HALTED on accepting opcode 0000. The halt instruction still appears at the output with out_halt=1.
  - HALTED: in_ready=0, the output drains normally, and later instructions are never accepted.
  - HALTED->RUN only on flush or reset.
- Load-use interlock:
  - shadow_valid/shadow_reg are set when a load (out_mem_read) transfers out (out_valid & out_ready). They clear on the next cycle or on flush.
  - hazard = shadow_valid & in_valid & (shadow_reg==RdRq index | shadow_reg==Rs index).
  - On hazard, exactly one bubble: out_valid=0 next cycle, then normal accept.
- Flush:
  - Takes priority over accept and over hold.
  - Next cycle: out_valid=0, shadow cleared, state RUN.
  - Register-file writes in the same cycle still occur.
- Reset (async assert, sync release by the environment):
  - out_valid=0 and all out_* = 0.
  - State RUN, shadow cleared, RF cleared.
  - A reset mid-stall or mid-halt returns to RUN.
- Simultaneous events:
  - wb to a source register in the accept cycle follows BYPASS.
  - Hazard and flush together: flush wins, no bubble.

Test Plan:
- ALU add 0xC250 after reset, wb r1=5 and r2=7 beforehand -> one cycle later out_valid=1, out_alu_ctrl=0000, out_reg2=5 (Rs=r1), out_wen=1, out_pc=in_pc_plus1.
- BYPASS=1: wb_en=1, wb_reg=1, wb_data=0xA5 in the same cycle an instruction with Rs=r1 is accepted -> out_reg2=0xA5. With BYPASS=0 -> the previous value.
- Load 0x8240 (wreg=r1) followed by an instruction with Rs=r1 -> exactly one bubble cycle (out_valid=0, in_ready=0), then the dependent instruction appears. A non-dependent follower gets no bubble.
- Halt 0x0000 accepted at pc=0x0010 -> out_halt=1, out_pc=0x0010, in_ready stays 0 for 10 further cycles. Then flush -> in_ready=1.
- out_ready=0 for 3 cycles with in_valid=1 -> output fields stable, in_ready=0. Release -> the next instruction loads with no loss or duplication.
- rst asserted low mid-stall -> immediately out_valid=0, RF reads 0. After release, normal accept.
